// File: rtl/booth_mul_arbiter_if.sv
// Buses around booth_mul_arbiter: the N-way client request/ack side and the
// shared 4-bit Booth engine side.
interface booth_req_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [4*N-1:0] a_bus;
  logic [4*N-1:0] b_bus;
  logic [N-1:0]   ack;
  logic [7:0]     prod_out;
  logic           err;
  logic           busy;
  logic [IDW-1:0] gnt_id;

  modport master (
    output req, a_bus, b_bus,
    input  ack, prod_out, err, busy, gnt_id
  );

  modport slave (
    input  req, a_bus, b_bus,
    output ack, prod_out, err, busy, gnt_id
  );
endinterface

interface booth_eng_if;
  logic       mul_en;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_prod;
  logic       mul_done;

  modport master (
    output mul_en, mul_a, mul_b,
    input  mul_prod, mul_done
  );

  modport slave (
    input  mul_en, mul_a, mul_b,
    output mul_prod, mul_done
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one Booth multiplier engine among N requesters; 8 cycles
// request-sample to ack, one op per 10 cycles; req is a held level, released by ack.
module booth_mul_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  booth_req_if.slave  cli,
  booth_eng_if.master eng
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] last, last_nx;
  logic [IDW-1:0] gnt, gnt_nx;
  logic [3:0]     op_a, op_a_nx;
  logic [3:0]     op_b, op_b_nx;
  logic           mul_en, mul_en_nx;
  logic [7:0]     prod, prod_nx;
  logic           err, err_nx;
  logic           busy, busy_nx;
  logic [N-1:0]   ack, ack_nx;
  logic [3:0]     tcnt, tcnt_nx;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] scan;

  // Walk upward from the slot after the last grant, wrapping at N-1.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = last;
    for (int k = 0; k < N; k++) begin
      scan = (scan == IDW'(N - 1)) ? '0 : scan + IDW'(1);
      if (!pick_vld && cli.req[scan]) begin
        pick_vld = 1'b1;
        pick_idx = scan;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    last_nx   = last;
    gnt_nx    = gnt;
    op_a_nx   = op_a;
    op_b_nx   = op_b;
    mul_en_nx = mul_en;
    prod_nx   = prod;
    err_nx    = err;
    busy_nx   = busy;
    ack_nx    = ack;
    tcnt_nx   = tcnt;

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nx    = pick_idx;
          last_nx   = pick_idx;
          op_a_nx   = cli.a_bus[{pick_idx, 2'b00} +: 4];
          op_b_nx   = cli.b_bus[{pick_idx, 2'b00} +: 4];
          busy_nx   = 1'b1;
          mul_en_nx = 1'b0;
          state_nx  = CLR;
        end
      end

      // The engine sees en low here for exactly one edge, flushing any stale done.
      CLR: begin
        mul_en_nx = 1'b1;
        tcnt_nx   = '0;
        state_nx  = RUN;
      end

      RUN: begin
        if (eng.mul_done) begin
          prod_nx      = eng.mul_prod;
          err_nx       = 1'b0;
          ack_nx       = '0;
          ack_nx[gnt]  = 1'b1;
          mul_en_nx    = 1'b0;
          state_nx     = RESP;
        end else if (tcnt == 4'(TIMEOUT - 1)) begin
          prod_nx      = '0;
          err_nx       = 1'b1;
          ack_nx       = '0;
          ack_nx[gnt]  = 1'b1;
          mul_en_nx    = 1'b0;
          state_nx     = RESP;
        end else begin
          tcnt_nx = tcnt + 4'd1;
        end
      end

      RESP: begin
        ack_nx   = '0;
        err_nx   = 1'b0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= IDW'(N - 1);
      gnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      mul_en <= 1'b0;
      prod   <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      ack    <= '0;
      tcnt   <= '0;
    end else begin
      state  <= state_nx;
      last   <= last_nx;
      gnt    <= gnt_nx;
      op_a   <= op_a_nx;
      op_b   <= op_b_nx;
      mul_en <= mul_en_nx;
      prod   <= prod_nx;
      err    <= err_nx;
      busy   <= busy_nx;
      ack    <= ack_nx;
      tcnt   <= tcnt_nx;
    end
  end

  assign cli.ack      = ack;
  assign cli.prod_out = prod;
  assign cli.err      = err;
  assign cli.busy     = busy;
  assign cli.gnt_id   = gnt;
  assign eng.mul_en   = mul_en;
  assign eng.mul_a    = op_a;
  assign eng.mul_b    = op_b;

  ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  ack_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
                                (ack != '0) == (state == RESP));

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized bench for booth_mul_arbiter with a behavioural Booth engine and a
// round-robin reference model.
module tb_booth_mul_arbiter;
  localparam int N = 4, IDW = 2, TIMEOUT = 12, W = 4 * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_req_if #(.N(N), .IDW(IDW)) cli();
  booth_eng_if eng();

  booth_mul_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cli   (cli),
    .eng   (eng)
  );

  // Engine: loads on the first enabled edge, iterates four edges, then raises done.
  bit stuck;
  int eng_cnt;
  always @(posedge clk) begin
    if (eng.mul_en !== 1'b1) begin
      eng_cnt       <= 0;
      eng.mul_done  <= 1'b0;
    end else if (eng_cnt < 5) begin
      eng_cnt <= eng_cnt + 1;
    end else if (!stuck) begin
      eng.mul_done <= 1'b1;
      eng.mul_prod <= $signed({{4{eng.mul_a[3]}}, eng.mul_a}) * $signed({{4{eng.mul_b[3]}}, eng.mul_b});
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int m_last;

  function automatic int pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++)
      if (((r >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [7:0] prod_of(logic [3:0] a, logic [3:0] b);
    int sa, sb;
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    return 8'(sa * sb);
  endfunction

  function automatic logic [3:0] slot(logic [W-1:0] bus, int i);
    return 4'(bus >> (4 * i));
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    return N'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (2) tick();
  endtask

  task automatic rand_ops();
    cli.a_bus = W'($urandom);
    cli.b_bus = W'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_last = N - 1;
  endtask

  // Waits for an ack; the acknowledged requester drops req before the next edge.
  task automatic wait_ack(input int limit, output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      tick();
      cyc++;
      if (cli.ack != '0) begin
        got = 1'b1;
        cli.req &= ~cli.ack;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stuck = 1'b0;
    cli.req = '0; cli.a_bus = '0; cli.b_bus = '0;
    repeat (3) tick();
    n_checks++; if (cli.ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", cli.ack); end
    n_checks++; if (cli.prod_out !== 8'h00) begin n_fail++; $display("FAIL reset_prod: got %h want 00", cli.prod_out); end
    n_checks++; if (cli.err !== 1'b0 || cli.busy !== 1'b0) begin n_fail++; $display("FAIL reset_err_busy: got %b%b want 00", cli.err, cli.busy); end
    n_checks++; if (cli.gnt_id !== '0) begin n_fail++; $display("FAIL reset_gnt: got %0d want 0", cli.gnt_id); end
    n_checks++; if (eng.mul_en !== 1'b0 || eng.mul_a !== 4'h0 || eng.mul_b !== 4'h0) begin n_fail++; $display("FAIL reset_engine: got en=%b a=%h b=%h want 0", eng.mul_en, eng.mul_a, eng.mul_b); end
    rst_n = 1'b1;
    m_last = N - 1;
    tick();
    n_checks++; if (cli.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", cli.busy); end
  endtask

  task automatic test_single();
    int cyc; bit got;
    logic [7:0] exp_prod;
    gap();
    cli.a_bus = W'(16'h000E);
    cli.b_bus = W'(16'h000E);
    exp_prod = prod_of(4'b1110, 4'b1110);
    cli.req = 4'b0001;
    tick();
    n_checks++; if (cli.busy !== 1'b1 || eng.mul_en !== 1'b0) begin n_fail++; $display("FAIL single_clr: got busy=%b en=%b want busy=1 en=0", cli.busy, eng.mul_en); end
    n_checks++; if (eng.mul_a !== 4'hE || eng.mul_b !== 4'hE) begin n_fail++; $display("FAIL single_ops: got %h %h want e e", eng.mul_a, eng.mul_b); end
    wait_ack(30, cyc, got);
    n_checks++; if (!got || cyc !== 8) begin n_fail++; $display("FAIL single_latency: got %0d (seen=%b) want 8", cyc, got); end
    n_checks++; if (cli.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", cli.ack); end
    n_checks++; if (cli.prod_out !== exp_prod) begin n_fail++; $display("FAIL single_prod: got %b want %b", cli.prod_out, exp_prod); end
    n_checks++; if (cli.err !== 1'b0 || cli.busy !== 1'b1) begin n_fail++; $display("FAIL single_flags: got err=%b busy=%b want 0 1", cli.err, cli.busy); end
    m_last = 0;
    tick();
    n_checks++; if (cli.ack !== '0 || cli.busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got ack=%b busy=%b want 0 0", cli.ack, cli.busy); end
    n_checks++; if (cli.prod_out !== exp_prod) begin n_fail++; $display("FAIL single_hold: got %b want %b", cli.prod_out, exp_prod); end
  endtask

  task automatic test_round_robin();
    int cyc, exp, spur; bit got;
    logic [7:0] exp_prod;
    do_reset();
    rand_ops();
    cli.req = 4'b1111;
    tick();
    for (int k = 0; k < N; k++) begin
      exp = pick(cli.req, m_last);
      exp_prod = prod_of(slot(cli.a_bus, exp), slot(cli.b_bus, exp));
      wait_ack(30, cyc, got);
      n_checks++; if (!got || cyc !== (k == 0 ? 8 : 10)) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, cyc, (k == 0 ? 8 : 10)); end
      n_checks++; if (cli.ack !== onehot(exp) || cli.gnt_id !== IDW'(exp)) begin n_fail++; $display("FAIL rr_grant[%0d]: got ack=%b gnt=%0d want %0d", k, cli.ack, cli.gnt_id, exp); end
      n_checks++; if (cli.prod_out !== exp_prod || cli.err !== 1'b0) begin n_fail++; $display("FAIL rr_prod[%0d]: got %h err=%b want %h", k, cli.prod_out, cli.err, exp_prod); end
      m_last = exp;
    end
    spur = 0;
    repeat (12) begin tick(); if (cli.ack != '0) spur++; end
    n_checks++; if (spur !== 0) begin n_fail++; $display("FAIL rr_spurious: got %0d acks want 0", spur); end
  endtask

  task automatic test_rr_wrap();
    int cyc, exp; bit got;
    gap();
    rand_ops();
    cli.req = 4'b0100;
    tick();
    wait_ack(30, cyc, got);
    n_checks++; if (!got || cli.ack !== 4'b0100) begin n_fail++; $display("FAIL wrap_first: got %b want 0100", cli.ack); end
    m_last = 2;
    tick();
    cli.req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      exp = pick(cli.req, m_last);
      wait_ack(30, cyc, got);
      n_checks++; if (!got || cli.ack !== onehot(exp) || cyc !== (k == 0 ? 9 : 10)) begin n_fail++; $display("FAIL wrap_order[%0d]: got ack=%b cyc=%0d want idx %0d", k, cli.ack, cyc, exp); end
      m_last = exp;
    end
  endtask

  task automatic test_products();
    int cyc; bit got;
    logic [7:0] exp_prod;
    gap();
    cli.a_bus = W'(16'h00B0);
    cli.b_bus = W'(16'h0020);
    exp_prod = prod_of(4'b1011, 4'b0010);
    cli.req = 4'b0010;
    repeat (3) tick();
    rand_ops();
    wait_ack(30, cyc, got);
    n_checks++; if (!got || cli.ack !== 4'b0010 || cli.prod_out !== exp_prod) begin n_fail++; $display("FAIL prod_neg: got ack=%b prod=%b want 0010 %b", cli.ack, cli.prod_out, exp_prod); end
    m_last = 1;
    gap();
    cli.a_bus = W'(16'h0700);
    cli.b_bus = W'(16'h0200);
    exp_prod = prod_of(4'b0111, 4'b0010);
    cli.req = 4'b0100;
    repeat (3) tick();
    rand_ops();
    wait_ack(30, cyc, got);
    n_checks++; if (!got || cli.ack !== 4'b0100 || cli.prod_out !== exp_prod) begin n_fail++; $display("FAIL prod_pos: got ack=%b prod=%b want 0100 %b", cli.ack, cli.prod_out, exp_prod); end
    m_last = 2;
  endtask

  task automatic test_timeout();
    int cyc; bit got;
    logic [7:0] exp_prod;
    gap();
    stuck = 1'b1;
    rand_ops();
    cli.req = 4'b0001;
    tick();
    wait_ack(40, cyc, got);
    n_checks++; if (!got || cyc !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d (seen=%b) want %0d", cyc, got, TIMEOUT + 1); end
    n_checks++; if (cli.ack !== 4'b0001 || cli.err !== 1'b1 || cli.prod_out !== 8'h00) begin n_fail++; $display("FAIL to_result: got ack=%b err=%b prod=%h want 0001 1 00", cli.ack, cli.err, cli.prod_out); end
    m_last = 0;
    tick();
    n_checks++; if (cli.err !== 1'b0 || cli.ack !== '0) begin n_fail++; $display("FAIL to_clear: got err=%b ack=%b want 0", cli.err, cli.ack); end
    stuck = 1'b0;
    gap();
    rand_ops();
    exp_prod = prod_of(slot(cli.a_bus, 3), slot(cli.b_bus, 3));
    cli.req = 4'b1000;
    tick();
    wait_ack(30, cyc, got);
    n_checks++; if (!got || cyc !== 8 || cli.err !== 1'b0 || cli.prod_out !== exp_prod) begin n_fail++; $display("FAIL to_recover: got cyc=%0d err=%b prod=%h want 8 0 %h", cyc, cli.err, cli.prod_out, exp_prod); end
    m_last = 3;
  endtask

  task automatic test_reset_mid_run();
    int cyc, exp; bit got;
    gap();
    rand_ops();
    cli.req = 4'b1010;
    repeat (5) tick();
    n_checks++; if (eng.mul_en !== 1'b1) begin n_fail++; $display("FAIL mid_running: got en=%b want 1", eng.mul_en); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_last = N - 1;
    n_checks++; if (cli.ack !== '0 || cli.err !== 1'b0 || cli.busy !== 1'b0 || cli.prod_out !== 8'h00 || cli.gnt_id !== '0) begin n_fail++; $display("FAIL mid_outputs: got ack=%b err=%b busy=%b prod=%h gnt=%0d want 0", cli.ack, cli.err, cli.busy, cli.prod_out, cli.gnt_id); end
    n_checks++; if (eng.mul_en !== 1'b0 || eng.mul_a !== 4'h0 || eng.mul_b !== 4'h0) begin n_fail++; $display("FAIL mid_engine: got en=%b a=%h b=%h want 0", eng.mul_en, eng.mul_a, eng.mul_b); end
    for (int k = 0; k < 2; k++) begin
      exp = pick(cli.req, m_last);
      wait_ack(30, cyc, got);
      n_checks++; if (!got || cli.ack !== onehot(exp) || cyc !== (k == 0 ? 9 : 10)) begin n_fail++; $display("FAIL mid_regrant[%0d]: got ack=%b cyc=%0d want idx %0d", k, cli.ack, cyc, exp); end
      m_last = exp;
    end
  endtask

  task automatic test_random();
    int cyc, exp; bit got;
    logic [7:0] exp_prod;
    gap();
    rand_ops();
    cli.req = N'($urandom_range(1, (1 << N) - 1));
    for (int it = 0; it < 24; it++) begin
      if (cli.req == '0) cli.req = N'($urandom_range(1, (1 << N) - 1));
      exp = pick(cli.req, m_last);
      exp_prod = prod_of(slot(cli.a_bus, exp), slot(cli.b_bus, exp));
      wait_ack(30, cyc, got);
      n_checks++; if (!got || cyc !== (it == 0 ? 9 : 10)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, cyc, (it == 0 ? 9 : 10)); end
      n_checks++; if (cli.ack !== onehot(exp) || cli.gnt_id !== IDW'(exp)) begin n_fail++; $display("FAIL rand_grant[%0d]: got ack=%b gnt=%0d want %0d", it, cli.ack, cli.gnt_id, exp); end
      n_checks++; if (cli.prod_out !== exp_prod || cli.err !== 1'b0) begin n_fail++; $display("FAIL rand_prod[%0d]: got %h err=%b want %h", it, cli.prod_out, cli.err, exp_prod); end
      m_last = exp;
      cli.req |= N'($urandom_range(0, (1 << N) - 1));
      rand_ops();
    end
    cli.req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_wrap();
    test_products();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
